// File: rtl/vcm_focus_seq_pkg.sv
// rtl/vcm_focus_seq_pkg.sv - shared types and write framing for the VCM focus sequencer
package vcm_focus_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WAIT_ACK, S_SETTLE, S_MEASURE, S_NEXT, S_PARK, S_DONE
    } state_e;

    typedef enum logic {
        PH_COARSE = 1'b0,
        PH_FINE   = 1'b1
    } phase_e;

    localparam logic [1:0] WR_PREFIX = 2'b00;
    localparam logic [3:0] WR_SUFFIX = 4'b1111;

endpackage

// File: rtl/vcm_focus_seq_if.sv
// rtl/vcm_focus_seq_if.sv - VCM write request/acknowledge handshake
interface vcm_focus_seq_if;

    logic        WR_REQ;
    logic [15:0] WR_DATA;
    logic        WR_ACK;

    modport master (output WR_REQ, output WR_DATA, input WR_ACK);
    modport slave  (input WR_REQ, input WR_DATA, output WR_ACK);

endinterface

// File: rtl/vcm_wr_hs.sv
// rtl/vcm_wr_hs.sv - holds WR_REQ/WR_DATA from a load pulse until WR_ACK
module vcm_wr_hs
    import vcm_focus_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [15:0]             load_data,
    output logic                    done,
    vcm_focus_seq_if.master         wr
);

    logic        req_q, req_d;
    logic [15:0] data_q, data_d;

    always_comb begin
        req_d  = req_q;
        data_d = data_q;
        done   = req_q & wr.WR_ACK;
        if (done) begin
            req_d = 1'b0;
        end
        if (load) begin
            req_d  = 1'b1;
            data_d = load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            data_q <= {WR_PREFIX, 10'd0, WR_SUFFIX};
        end else begin
            req_q  <= req_d;
            data_q <= data_d;
        end
    end

    assign wr.WR_REQ  = req_q;
    assign wr.WR_DATA = data_q;

endmodule

// File: rtl/vcm_focus_seq.sv
// rtl/vcm_focus_seq.sv - frame-synchronous coarse/fine auto-focus sweep with peak park
module vcm_focus_seq
    import vcm_focus_seq_pkg::*;
#(
    parameter int STEP_W     = 10,
    parameter int SUM_W      = 32,
    parameter int COARSE_INC = 64,
    parameter int FINE_INC   = 8,
    parameter int MAX_STEP   = 1023,
    parameter int SETTLE_FR  = 2
) (
    input  logic               VIDEO_CLK,
    input  logic               RESET_n,
    input  logic               AUTO_FOC,
    input  logic               VS,
    input  logic               SUM_VALID,
    input  logic [SUM_W-1:0]   SUM,
    vcm_focus_seq_if.master    wr,
    output logic [STEP_W-1:0]  STEP,
    output logic [STEP_W-1:0]  PEAK_STEP,
    output logic [SUM_W-1:0]   PEAK_SUM,
    output logic               BUSY,
    output logic               VCM_END
);

    localparam int CNT_W = (SETTLE_FR > 1) ? $clog2(SETTLE_FR) : 1;
    typedef logic [STEP_W:0] stepx_t;

    state_e              state_q, state_d;
    phase_e              phase_q, phase_d;
    logic [STEP_W-1:0]   step_q, step_d, peak_step_q, peak_step_d, hi_q, hi_d;
    logic [SUM_W-1:0]    peak_sum_q, peak_sum_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d, end_q, end_d, park_q, park_d, abort_q, abort_d;
    logic                foc_q, foc_d, vs_q, vs_d;
    logic                load, wr_done, foc_rise, vs_rise;
    stepx_t              inc_sum, peak_plus;
    logic [STEP_W-1:0]   fine_lo, fine_hi;

    vcm_wr_hs u_wr_hs (
        .clk       (VIDEO_CLK),
        .rst_n     (RESET_n),
        .load      (load),
        .load_data ({WR_PREFIX, step_q, WR_SUFFIX}),
        .done      (wr_done),
        .wr        (wr)
    );

    // Widened by one bit so a step past MAX_STEP is visible rather than wrapping.
    always_comb begin
        inc_sum   = {1'b0, step_q} + ((phase_q == PH_COARSE) ? stepx_t'(COARSE_INC) : stepx_t'(FINE_INC));
        peak_plus = {1'b0, peak_step_q} + stepx_t'(COARSE_INC);
        fine_lo   = ({1'b0, peak_step_q} >= stepx_t'(COARSE_INC)) ? peak_step_q - STEP_W'(COARSE_INC) : '0;
        fine_hi   = (peak_plus > stepx_t'(MAX_STEP)) ? STEP_W'(MAX_STEP) : peak_plus[STEP_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = step_q;
        peak_step_d = peak_step_q;
        peak_sum_d  = peak_sum_q;
        hi_d        = hi_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        end_d       = end_q;
        park_d      = park_q;
        abort_d     = abort_q;
        foc_d       = AUTO_FOC;
        vs_d        = VS;
        foc_rise    = AUTO_FOC & ~foc_q;
        vs_rise     = VS & ~vs_q;
        load        = 1'b0;

        if (!AUTO_FOC && (state_q inside {S_WRITE, S_SETTLE, S_MEASURE, S_NEXT, S_PARK})) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (foc_rise) begin
                        step_d      = '0;
                        peak_step_d = '0;
                        peak_sum_d  = '0;
                        phase_d     = PH_COARSE;
                        park_d      = 1'b0;
                        abort_d     = 1'b0;
                        busy_d      = 1'b1;
                        end_d       = 1'b0;
                        state_d     = S_WRITE;
                    end
                end
                S_WRITE: begin
                    load    = 1'b1;
                    state_d = S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // An abort here waits for the ack so the handshake is never broken.
                    abort_d = abort_q | ~AUTO_FOC;
                    if (wr_done) begin
                        abort_d = 1'b0;
                        cnt_d   = '0;
                        if (abort_q || !AUTO_FOC) begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end else if (park_q) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            end_d   = 1'b1;
                        end else begin
                            state_d = S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (vs_rise) begin
                        if (cnt_q == CNT_W'(SETTLE_FR - 1)) begin
                            cnt_d   = '0;
                            state_d = S_MEASURE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_MEASURE: begin
                    if (SUM_VALID) begin
                        if (SUM > peak_sum_q) begin
                            peak_sum_d  = SUM;
                            peak_step_d = step_q;
                        end
                        state_d = S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (phase_q == PH_COARSE) begin
                        if (inc_sum <= stepx_t'(MAX_STEP)) begin
                            step_d = inc_sum[STEP_W-1:0];
                        end else begin
                            phase_d = PH_FINE;
                            step_d  = fine_lo;
                            hi_d    = fine_hi;
                        end
                        state_d = S_WRITE;
                    end else if (inc_sum <= {1'b0, hi_q}) begin
                        step_d  = inc_sum[STEP_W-1:0];
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_PARK;
                    end
                end
                S_PARK: begin
                    step_d  = peak_step_q;
                    park_d  = 1'b1;
                    state_d = S_WRITE;
                end
                S_DONE: begin
                    if (!AUTO_FOC) begin
                        end_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // foc_q resets high: a level already high when reset releases is not a start request.
    always_ff @(posedge VIDEO_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q     <= S_IDLE;
            phase_q     <= PH_COARSE;
            step_q      <= '0;
            peak_step_q <= '0;
            peak_sum_q  <= '0;
            hi_q        <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            end_q       <= 1'b0;
            park_q      <= 1'b0;
            abort_q     <= 1'b0;
            foc_q       <= 1'b1;
            vs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            peak_step_q <= peak_step_d;
            peak_sum_q  <= peak_sum_d;
            hi_q        <= hi_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            end_q       <= end_d;
            park_q      <= park_d;
            abort_q     <= abort_d;
            foc_q       <= foc_d;
            vs_q        <= vs_d;
        end
    end

    assign STEP      = step_q;
    assign PEAK_STEP = peak_step_q;
    assign PEAK_SUM  = peak_sum_q;
    assign BUSY      = busy_q;
    assign VCM_END   = end_q;

endmodule

// File: tb/tb_vcm_focus_seq.sv
// tb/tb_vcm_focus_seq.sv - directed self-checking bench for vcm_focus_seq
module tb_vcm_focus_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        af = 1'b0;
    logic        env_en = 1'b0;
    logic        env_vs, env_sv, env_ack;
    logic [31:0] env_sum;
    logic        man_vs = 1'b0, man_sv = 1'b0, man_ack = 1'b0;
    logic [31:0] man_sum = '0;
    logic [9:0]  step, peak_step;
    logic [31:0] peak_sum;
    logic        busy, vcm_end;

    int          checks = 0;
    int          errors = 0;
    int          cur_model = 0;
    int          cur_dly = 0;
    int          lens = 0;
    int          hold_err = 0;
    logic [15:0] wr_log[$];

    vcm_focus_seq_if wr_if();
    assign wr_if.WR_ACK = env_en ? env_ack : man_ack;

    vcm_focus_seq dut (
        .VIDEO_CLK (clk),
        .RESET_n   (rst_n),
        .AUTO_FOC  (af),
        .VS        (env_en ? env_vs : man_vs),
        .SUM_VALID (env_en ? env_sv : man_sv),
        .SUM       (env_en ? env_sum : man_sum),
        .wr        (wr_if),
        .STEP      (step),
        .PEAK_STEP (peak_step),
        .PEAK_SUM  (peak_sum),
        .BUSY      (busy),
        .VCM_END   (vcm_end)
    );

    always #5 clk = ~clk;

    function automatic int model_sum(input int m, input int p);
        case (m)
            0:       return 1000 - ((p > 300) ? p - 300 : 300 - p);
            1:       return 2000 - p;
            default: return p;
        endcase
    endfunction

    // Camera: 24-cycle frames, VS high 4 cycles, sum of the current lens position mid-frame.
    initial begin
        int fcnt;
        fcnt = 0; env_vs = 1'b0; env_sv = 1'b0; env_sum = '0;
        forever begin
            @(negedge clk);
            fcnt    = (fcnt + 1) % 24;
            env_vs  = (fcnt < 4);
            env_sv  = (fcnt == 10);
            env_sum = 32'(model_sum(cur_model, lens));
        end
    end

    // VCM writer: acks after cur_dly cycles, logs accepted data, checks data stays put.
    initial begin
        int          ack_cnt;
        logic [15:0] held;
        ack_cnt = 0; held = '0; env_ack = 1'b0;
        forever begin
            @(negedge clk);
            env_ack = 1'b0;
            if (env_en && wr_if.WR_REQ) begin
                if (ack_cnt == 0) held = wr_if.WR_DATA;
                else if (wr_if.WR_DATA !== held) hold_err++;
                if (ack_cnt == cur_dly) begin
                    env_ack = 1'b1;
                    wr_log.push_back(wr_if.WR_DATA);
                    lens    = int'(wr_if.WR_DATA[13:4]);
                    ack_cnt = 0;
                end else begin
                    ack_cnt++;
                end
            end else begin
                ack_cnt = 0;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_req(input string nm);
        int k;
        for (k = 0; k < 200 && !wr_if.WR_REQ; k++) tick(1);
        chk({nm, "_req_timeout"}, 64'(wr_if.WR_REQ), 64'd1);
    endtask

    task automatic ack_pulse();
        man_ack = 1'b1; tick(1); man_ack = 1'b0;
    endtask

    task automatic vs_edge();
        man_vs = 1'b1; tick(1); man_vs = 1'b0; tick(1);
    endtask

    task automatic sv_pulse(input logic [31:0] s);
        man_sum = s; man_sv = 1'b1; tick(1); man_sv = 1'b0;
    endtask

    task automatic do_step(input string nm, input logic [31:0] s);
        wait_req(nm); ack_pulse(); vs_edge(); vs_edge(); sv_pulse(s); tick(1);
    endtask

    typedef struct {
        int model;
        int dly;
        int nwr;
        int lo;
        int peak;
        int psum;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int k;
        vecs[0] = '{model: 0, dly: 1,  nwr: 34, lo: 256, peak: 296,  psum: 996};
        vecs[1] = '{model: 1, dly: 0,  nwr: 26, lo: 0,   peak: 0,    psum: 2000};
        vecs[2] = '{model: 2, dly: 50, nwr: 33, lo: 896, peak: 1016, psum: 1016};

        tick(3);
        chk("rst_wr_req",  64'(wr_if.WR_REQ), 64'd0);
        chk("rst_wr_data", 64'(wr_if.WR_DATA), 64'h000F);
        chk("rst_step",    64'(step), 64'd0);
        chk("rst_peak",    64'(peak_sum), 64'd0);
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_end",     64'(vcm_end), 64'd0);
        rst_n = 1'b1;
        tick(3);

        env_en = 1'b1;
        for (int v = 0; v < 3; v++) begin
            cur_model = vecs[v].model;
            cur_dly   = vecs[v].dly;
            wr_log.delete();
            hold_err  = 0;
            lens      = 0;
            af        = 1'b1;
            for (k = 0; k < 30000 && !vcm_end; k++) tick(1);
            chk($sformatf("v%0d_end", v), 64'(vcm_end), 64'd1);
            chk($sformatf("v%0d_busy", v), 64'(busy), 64'd0);
            chk($sformatf("v%0d_peak_step", v), 64'(peak_step), 64'(vecs[v].peak));
            chk($sformatf("v%0d_peak_sum", v), 64'(peak_sum), 64'(vecs[v].psum));
            chk($sformatf("v%0d_step_parked", v), 64'(step), 64'(vecs[v].peak));
            chk($sformatf("v%0d_nwr", v), 64'(wr_log.size()), 64'(vecs[v].nwr));
            chk($sformatf("v%0d_hold", v), 64'(hold_err), 64'd0);
            if (wr_log.size() >= 17) begin
                chk($sformatf("v%0d_wr0", v), 64'(wr_log[0]), 64'h000F);
                chk($sformatf("v%0d_wr15", v), 64'(wr_log[15]), 64'h3C0F);
                chk($sformatf("v%0d_wr16", v), 64'(wr_log[16]), 64'((vecs[v].lo << 4) | 15));
                chk($sformatf("v%0d_park_wd", v), 64'(wr_log[$]), 64'((vecs[v].peak << 4) | 15));
            end else begin
                chk($sformatf("v%0d_log_short", v), 64'(wr_log.size()), 64'd17);
            end
            af = 1'b0;
            tick(2);
            chk($sformatf("v%0d_end_clear", v), 64'(vcm_end), 64'd0);
        end
        env_en = 1'b0;
        tick(2);

        // Settle-frame sums ignored, including one coincident with the last settle edge.
        af = 1'b1;
        wait_req("b0");
        chk("b_first_wd", 64'(wr_if.WR_DATA), 64'h000F);
        ack_pulse();
        sv_pulse(32'hFFFF_FFFF);
        vs_edge();
        sv_pulse(32'hFFFF_FFFF);
        man_vs = 1'b1; man_sv = 1'b1; man_sum = 32'hFFFF_FFFF;
        tick(1);
        man_vs = 1'b0; man_sv = 1'b0;
        tick(1);
        sv_pulse(32'd5);
        tick(1);
        chk("b_peak_sum", 64'(peak_sum), 64'd5);
        chk("b_peak_step", 64'(peak_step), 64'd0);
        wait_req("b1");
        chk("b_step64", 64'(step), 64'd64);
        chk("b_wd64", 64'(wr_if.WR_DATA), 64'h040F);
        af = 1'b0;
        tick(5);
        chk("b_abort_req_held", 64'(wr_if.WR_REQ), 64'd1);
        chk("b_abort_wd_held", 64'(wr_if.WR_DATA), 64'h040F);
        ack_pulse();
        chk("b_abort_req_low", 64'(wr_if.WR_REQ), 64'd0);
        chk("b_abort_busy", 64'(busy), 64'd0);
        chk("b_abort_step", 64'(step), 64'd64);
        chk("b_abort_peak", 64'(peak_sum), 64'd5);
        tick(10);
        chk("b_idle_no_req", 64'(wr_if.WR_REQ), 64'd0);

        // Abort during SETTLE at step 128.
        af = 1'b1;
        do_step("c0", 32'd10);
        do_step("c1", 32'd20);
        wait_req("c2");
        chk("c_wd128", 64'(wr_if.WR_DATA), 64'h080F);
        ack_pulse();
        vs_edge();
        af = 1'b0;
        tick(1);
        chk("c_busy", 64'(busy), 64'd0);
        chk("c_step", 64'(step), 64'd128);
        chk("c_peak_step", 64'(peak_step), 64'd64);
        chk("c_peak_sum", 64'(peak_sum), 64'd20);
        tick(20);
        chk("c_no_req", 64'(wr_if.WR_REQ), 64'd0);

        // Asynchronous reset in the middle of WAIT_ACK.
        af = 1'b1;
        do_step("d0", 32'd77);
        wait_req("d1");
        chk("d_peak_before", 64'(peak_sum), 64'd77);
        #2 rst_n = 1'b0;
        #1;
        chk("d_rst_req", 64'(wr_if.WR_REQ), 64'd0);
        chk("d_rst_wd", 64'(wr_if.WR_DATA), 64'h000F);
        chk("d_rst_step", 64'(step), 64'd0);
        chk("d_rst_peak", 64'(peak_sum), 64'd0);
        chk("d_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (wr_if.WR_REQ) k++;
        end
        chk("d_no_req_after_rst", 64'(k), 64'd0);
        af = 1'b0;
        tick(2);
        af = 1'b1;
        wait_req("d2");
        chk("d_restart_wd", 64'(wr_if.WR_DATA), 64'h000F);
        af = 1'b0;
        ack_pulse();
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
